// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Memory-side bus between the load/store unit and the data memory.
//   Bus_Req_o    : request strobe, held for the whole access
//   Bus_We_o     : 1 = store, 0 = load
//   Bus_Addr_o   : word-aligned byte address (bits 1:0 always 00)
//   Bus_Wdata_o  : lane-replicated store data
//   Bus_Be_o     : byte-lane enables (also driven for loads)
//   Bus_Ack_i    : memory completion strobe
//   Bus_Rdata_i  : full read word returned with the ack
// The _o/_i suffixes are named from the load/store unit's point of view.
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        Bus_Req_o;
  logic        Bus_We_o;
  logic [31:0] Bus_Addr_o;
  logic [31:0] Bus_Wdata_o;
  logic [3:0]  Bus_Be_o;
  logic        Bus_Ack_i;
  logic [31:0] Bus_Rdata_i;

  modport master (
    output Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_Wdata_o, Bus_Be_o,
    input  Bus_Ack_i, Bus_Rdata_i
  );

  modport slave (
    input  Bus_Req_o, Bus_We_o, Bus_Addr_o, Bus_Wdata_o, Bus_Be_o,
    output Bus_Ack_i, Bus_Rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Translates core load/store requests into single-word bus transactions and
// returns sign/zero-extended load data.
//   clk, reset     : clock, asynchronous active-low reset
//   Mem_Read_i     : load request          Mem_Write_i : store request
//   funct3_i       : access size / sign    Address_i   : byte address
//   Write_Data_i   : store data (rs2)
//   Stall_o        : core holds PC/instruction while high
//   Done_o         : one-cycle completion (or abort) pulse
//   Read_Data_o    : extended load result, valid with Done_o
//   Misaligned_o   : one-cycle pulse, misaligned/illegal access
//   Bus_Err_o      : one-cycle pulse, bus timeout
//   bus            : memory bus (master side)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Mem_Read_i,
  input  logic                     Mem_Write_i,
  input  logic [2:0]               funct3_i,
  input  logic [31:0]              Address_i,
  input  logic [31:0]              Write_Data_i,
  output logic                     Stall_o,
  output logic                     Done_o,
  output logic [31:0]              Read_Data_o,
  output logic                     Misaligned_o,
  output logic                     Bus_Err_o,
  load_store_unit_if.master        bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lane_q;
  logic [2:0]        f3_q;

  logic f3_ok;
  logic misal;
  logic accept;
  logic reject;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed lane out of the bus word and extend it; funct3[2]
  // distinguishes unsigned (LBU/LHU) from signed (LB/LH) loads.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request decode, evaluated only while idle. Two simultaneous requests are
  // treated as an illegal access and reported through Misaligned_o.
  always_comb begin
    f3_ok  = f3_legal(Mem_Read_i, funct3_i);
    misal  = ((funct3_i[1:0] == 2'b01) && Address_i[0]) ||
             ((funct3_i[1:0] == 2'b10) && (Address_i[1:0] != 2'b00));
    accept = (Mem_Read_i ^ Mem_Write_i) && f3_ok && !misal;
    reject = (Mem_Read_i | Mem_Write_i) && !accept;
  end

  // Stall rises in the same cycle the request is accepted so the core does
  // not advance past the instruction; gated so it is 0 during reset too.
  assign Stall_o = reset && ((state == S_REQ) || ((state == S_IDLE) && accept));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      lane_q          <= '0;
      f3_q            <= '0;
      Done_o          <= 1'b0;
      Read_Data_o     <= '0;
      Misaligned_o    <= 1'b0;
      Bus_Err_o       <= 1'b0;
      bus.Bus_Req_o   <= 1'b0;
      bus.Bus_We_o    <= 1'b0;
      bus.Bus_Addr_o  <= '0;
      bus.Bus_Wdata_o <= '0;
      bus.Bus_Be_o    <= '0;
    end else begin
      // Status outputs are pulses: asserted only on entry to DONE/ERR.
      Done_o       <= 1'b0;
      Read_Data_o  <= '0;
      Misaligned_o <= 1'b0;
      Bus_Err_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state           <= S_REQ;
            cnt             <= '0;
            lane_q          <= Address_i[1:0];
            f3_q            <= funct3_i;
            bus.Bus_Req_o   <= 1'b1;
            bus.Bus_We_o    <= Mem_Write_i;
            bus.Bus_Addr_o  <= {Address_i[31:2], 2'b00};
            bus.Bus_Wdata_o <= Mem_Write_i ? replicate_wdata(funct3_i[1:0], Write_Data_i) : '0;
            bus.Bus_Be_o    <= byte_enable(funct3_i[1:0], Address_i[1:0]);
          end else if (reject) begin
            state        <= S_ERR;
            Done_o       <= 1'b1;
            Misaligned_o <= 1'b1;
          end
        end
        S_REQ: begin
          // An ack in the final counted cycle still completes normally.
          if (bus.Bus_Ack_i || (cnt == CNT_LAST)) begin
            state           <= bus.Bus_Ack_i ? S_DONE : S_ERR;
            Done_o          <= 1'b1;
            Bus_Err_o       <= !bus.Bus_Ack_i;
            Read_Data_o     <= (bus.Bus_Ack_i && !bus.Bus_We_o) ?
                               load_extend(f3_q, lane_q, bus.Bus_Rdata_i) : '0;
            bus.Bus_Req_o   <= 1'b0;
            bus.Bus_We_o    <= 1'b0;
            bus.Bus_Addr_o  <= '0;
            bus.Bus_Wdata_o <= '0;
            bus.Bus_Be_o    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Read_i, Mem_Write_i;
  logic [2:0]  funct3_i;
  logic [31:0] Address_i, Write_Data_i;
  logic        Stall_o, Done_o, Misaligned_o, Bus_Err_o;
  logic [31:0] Read_Data_o;

  int checks = 0;
  int errors = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .Mem_Read_i   (Mem_Read_i),
    .Mem_Write_i  (Mem_Write_i),
    .funct3_i     (funct3_i),
    .Address_i    (Address_i),
    .Write_Data_i (Write_Data_i),
    .Stall_o      (Stall_o),
    .Done_o       (Done_o),
    .Read_Data_o  (Read_Data_o),
    .Misaligned_o (Misaligned_o),
    .Bus_Err_o    (Bus_Err_o),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load with ack in the first REQ cycle; returns what the bus and core saw.
  task automatic load_access(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                             output logic [3:0] be, output logic [31:0] addr_seen,
                             output logic [31:0] rd, output logic done_seen);
    tick();
    Mem_Read_i = 1'b1; funct3_i = f3; Address_i = a;
    tick();
    Mem_Read_i = 1'b0;
    be = bus_if.Bus_Be_o; addr_seen = bus_if.Bus_Addr_o;
    bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = rdata;
    tick();
    bus_if.Bus_Ack_i = 1'b0;
    rd = Read_Data_o; done_seen = Done_o;
  endtask

  task automatic store_access(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              output logic we, output logic [31:0] addr_seen, output logic [3:0] be,
                              output logic [31:0] wdata, output logic [31:0] rd, output logic done_seen);
    tick();
    Mem_Write_i = 1'b1; funct3_i = f3; Address_i = a; Write_Data_i = wd;
    tick();
    Mem_Write_i = 1'b0;
    we = bus_if.Bus_We_o; addr_seen = bus_if.Bus_Addr_o; be = bus_if.Bus_Be_o; wdata = bus_if.Bus_Wdata_o;
    bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = 32'hFFFF_FFFF;
    tick();
    bus_if.Bus_Ack_i = 1'b0;
    rd = Read_Data_o; done_seen = Done_o;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Mem_Read_i = 1'b1; Mem_Write_i = 1'b0; funct3_i = 3'b010;
    Address_i = 32'h104; Write_Data_i = 32'h0;
    bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = 32'h0;
    #2;
    checks++; if (Stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall_o); end
    repeat (2) tick();
    checks++;
    if ({bus_if.Bus_Req_o, bus_if.Bus_We_o, Done_o, Misaligned_o, Bus_Err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000",
                         {bus_if.Bus_Req_o, bus_if.Bus_We_o, Done_o, Misaligned_o, Bus_Err_o});
    end
    checks++;
    if ({bus_if.Bus_Addr_o, bus_if.Bus_Wdata_o, bus_if.Bus_Be_o, Read_Data_o} !== 100'd0) begin
      errors++; $display("FAIL reset_data got addr %h wdata %h be %b rd %h want all 0",
                         bus_if.Bus_Addr_o, bus_if.Bus_Wdata_o, bus_if.Bus_Be_o, Read_Data_o);
    end
    Mem_Read_i = 1'b0; bus_if.Bus_Ack_i = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus_if.Bus_Req_o, Done_o, Stall_o} !== 3'b0) begin
      errors++; $display("FAIL reset_idle got %b want 000", {bus_if.Bus_Req_o, Done_o, Stall_o});
    end
  endtask

  task automatic test_lw();
    tick();
    Mem_Read_i = 1'b1; funct3_i = 3'b010; Address_i = 32'h0000_0104;
    #1;
    checks++; if (Stall_o !== 1'b1) begin errors++; $display("FAIL lw_stall_idle got %b want 1", Stall_o); end
    tick();
    Mem_Read_i = 1'b0;
    checks++;
    if ({bus_if.Bus_Req_o, bus_if.Bus_We_o, Stall_o, Done_o} !== 4'b1010) begin
      errors++; $display("FAIL lw_req_ctrl got %b want 1010",
                         {bus_if.Bus_Req_o, bus_if.Bus_We_o, Stall_o, Done_o});
    end
    checks++;
    if (bus_if.Bus_Addr_o !== 32'h104) begin errors++; $display("FAIL lw_addr got %h want 00000104", bus_if.Bus_Addr_o); end
    checks++;
    if (bus_if.Bus_Be_o !== 4'b1111) begin errors++; $display("FAIL lw_be got %b want 1111", bus_if.Bus_Be_o); end
    bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = 32'hDEAD_BEEF;
    tick();
    bus_if.Bus_Ack_i = 1'b0;
    checks++;
    if ({Done_o, Stall_o, bus_if.Bus_Req_o} !== 3'b100) begin
      errors++; $display("FAIL lw_done got %b want 100", {Done_o, Stall_o, bus_if.Bus_Req_o});
    end
    checks++;
    if (Read_Data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", Read_Data_o); end
    tick();
    checks++;
    if ({Done_o, Read_Data_o} !== 33'd0) begin
      errors++; $display("FAIL lw_pulse got done %b rd %h want 0 0", Done_o, Read_Data_o);
    end
  endtask

  task automatic test_load_ext();
    logic [3:0] be; logic [31:0] a, rd; logic dn;
    load_access(3'b000, 32'h103, 32'h80FF_0000, be, a, rd, dn);
    checks++;
    if ({be, a} !== {4'b1000, 32'h100}) begin errors++; $display("FAIL lb_bus got be %b addr %h want 1000 00000100", be, a); end
    checks++;
    if ({dn, rd} !== {1'b1, 32'hFFFF_FF80}) begin errors++; $display("FAIL lb_rdata got done %b rd %h want 1 ffffff80", dn, rd); end
    load_access(3'b100, 32'h103, 32'h80FF_0000, be, a, rd, dn);
    checks++;
    if ({dn, rd} !== {1'b1, 32'h0000_0080}) begin errors++; $display("FAIL lbu_rdata got done %b rd %h want 1 00000080", dn, rd); end
    load_access(3'b001, 32'h102, 32'h80FF_0000, be, a, rd, dn);
    checks++;
    if (be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", be); end
    checks++;
    if (rd !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_rdata got %h want ffff80ff", rd); end
    load_access(3'b101, 32'h102, 32'h80FF_0000, be, a, rd, dn);
    checks++;
    if (rd !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_rdata got %h want 000080ff", rd); end
    load_access(3'b000, 32'h100, 32'h1234_567F, be, a, rd, dn);
    checks++;
    if ({be, rd} !== {4'b0001, 32'h0000_007F}) begin errors++; $display("FAIL lb_lane0 got be %b rd %h want 0001 0000007f", be, rd); end
  endtask

  task automatic test_store();
    logic we, dn; logic [31:0] a, wd, rd; logic [3:0] be;
    store_access(3'b000, 32'h201, 32'h1234_56AB, we, a, be, wd, rd, dn);
    checks++;
    if ({we, a, be} !== {1'b1, 32'h200, 4'b0010}) begin
      errors++; $display("FAIL sb_bus got we %b addr %h be %b want 1 00000200 0010", we, a, be);
    end
    checks++;
    if (wd !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", wd); end
    checks++;
    if ({dn, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL sb_done got done %b rd %h want 1 00000000", dn, rd); end
    store_access(3'b001, 32'h202, 32'h1234_56AB, we, a, be, wd, rd, dn);
    checks++;
    if ({be, wd} !== {4'b1100, 32'h56AB_56AB}) begin
      errors++; $display("FAIL sh_bus got be %b wdata %h want 1100 56ab56ab", be, wd);
    end
    store_access(3'b010, 32'h204, 32'hCAFE_F00D, we, a, be, wd, rd, dn);
    checks++;
    if ({a, be, wd} !== {32'h204, 4'b1111, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL sw_bus got addr %h be %b wdata %h want 00000204 1111 cafef00d", a, be, wd);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0] f3_tab [3] = '{3'b010, 3'b011, 3'b001};
    logic [31:0] a_tab [3] = '{32'h102, 32'h100, 32'h101};
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        Mem_Read_i = 1'b1; funct3_i = f3_tab[i]; Address_i = a_tab[i];
      end else begin
        Mem_Read_i = 1'b1; Mem_Write_i = 1'b1; funct3_i = 3'b010; Address_i = 32'h100;
      end
      #1;
      checks++;
      if ({Stall_o, bus_if.Bus_Req_o} !== 2'b00) begin
        errors++; $display("FAIL mis_idle[%0d] got stall/req %b want 00", i, {Stall_o, bus_if.Bus_Req_o});
      end
      tick();
      Mem_Read_i = 1'b0; Mem_Write_i = 1'b0;
      checks++;
      if ({Done_o, Misaligned_o, Bus_Err_o, bus_if.Bus_Req_o, Stall_o} !== 5'b11000 || Read_Data_o !== 32'h0) begin
        errors++; $display("FAIL mis_resp[%0d] got done/mis/err/req/stall %b rd %h want 11000 0", i,
                           {Done_o, Misaligned_o, Bus_Err_o, bus_if.Bus_Req_o, Stall_o}, Read_Data_o);
      end
      tick();
      checks++;
      if ({Done_o, Misaligned_o, bus_if.Bus_Req_o} !== 3'b000) begin
        errors++; $display("FAIL mis_after[%0d] got %b want 000", i, {Done_o, Misaligned_o, bus_if.Bus_Req_o});
      end
    end
  endtask

  task automatic test_ack_outside_req();
    int dn = 0;
    bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Done_o || bus_if.Bus_Req_o) dn++;
    end
    bus_if.Bus_Ack_i = 1'b0;
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL ack_idle got %0d active cycles want 0", dn); end
  endtask

  task automatic test_timeout(input bit late_ack);
    int n = 0;
    bit fin = 1'b0;
    tick();
    Mem_Read_i = 1'b1; funct3_i = 3'b010; Address_i = 32'h400;
    for (int i = 0; i < 40 && !fin; i++) begin
      tick();
      Mem_Read_i = 1'b0;
      if (Done_o) begin
        fin = 1'b1;
        bus_if.Bus_Ack_i = 1'b0;
      end else if (bus_if.Bus_Req_o) begin
        n++;
        if (late_ack && n == 16) begin bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = 32'h55AA_1234; end
      end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL timeout_done got no Done_o in 40 cycles want pulse"); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d want 16", n); end
    if (!late_ack) begin
      checks++;
      if ({Bus_Err_o, Misaligned_o, Read_Data_o} !== {2'b10, 32'h0}) begin
        errors++; $display("FAIL timeout_err got err %b mis %b rd %h want 1 0 00000000", Bus_Err_o, Misaligned_o, Read_Data_o);
      end
      tick();
      checks++;
      if ({Bus_Err_o, Done_o} !== 2'b00) begin errors++; $display("FAIL timeout_pulse got %b want 00", {Bus_Err_o, Done_o}); end
    end else begin
      checks++;
      if ({Bus_Err_o, Read_Data_o} !== {1'b0, 32'h55AA_1234}) begin
        errors++; $display("FAIL late_ack got err %b rd %h want 0 55aa1234", Bus_Err_o, Read_Data_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    logic [3:0] be; logic [31:0] a, rd; logic d;
    tick();
    Mem_Read_i = 1'b1; funct3_i = 3'b010; Address_i = 32'h500;
    repeat (3) begin
      tick();
      Mem_Read_i = 1'b0;
    end
    checks++;
    if (bus_if.Bus_Req_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre got req %b want 1", bus_if.Bus_Req_o); end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_if.Bus_Req_o, Stall_o} !== 2'b00) begin
      errors++; $display("FAIL rstmid_async got req/stall %b want 00", {bus_if.Bus_Req_o, Stall_o});
    end
    #2 reset = 1'b1;
    repeat (4) begin
      tick();
      if (Done_o || bus_if.Bus_Req_o) dn++;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", dn); end
    load_access(3'b010, 32'h504, 32'h0BAD_F00D, be, a, rd, d);
    checks++;
    if ({d, rd, a} !== {1'b1, 32'h0BAD_F00D, 32'h504}) begin
      errors++; $display("FAIL rstmid_next got done %b rd %h addr %h want 1 0badf00d 00000504", d, rd, a);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] be; logic [31:0] a, rd; logic d;
    tick();
    Mem_Read_i = 1'b1; funct3_i = 3'b010; Address_i = 32'h600;
    tick();
    // Requests raised during REQ must not start another access.
    Mem_Read_i = 1'b0; Mem_Write_i = 1'b1; Address_i = 32'h700; funct3_i = 3'b010;
    tick();
    checks++;
    if ({bus_if.Bus_Req_o, bus_if.Bus_Addr_o, bus_if.Bus_We_o} !== {1'b1, 32'h600, 1'b0}) begin
      errors++; $display("FAIL b2b_hold got req %b addr %h we %b want 1 00000600 0",
                         bus_if.Bus_Req_o, bus_if.Bus_Addr_o, bus_if.Bus_We_o);
    end
    Mem_Write_i = 1'b0;
    bus_if.Bus_Ack_i = 1'b1; bus_if.Bus_Rdata_i = 32'h7777_0001;
    tick();
    bus_if.Bus_Ack_i = 1'b0;
    checks++;
    if ({Done_o, Read_Data_o} !== {1'b1, 32'h7777_0001}) begin
      errors++; $display("FAIL b2b_first got done %b rd %h want 1 77770001", Done_o, Read_Data_o);
    end
    tick();
    checks++;
    if ({bus_if.Bus_Req_o, Done_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_gap got req/done %b want 00", {bus_if.Bus_Req_o, Done_o});
    end
    load_access(3'b001, 32'h600, 32'h0000_8001, be, a, rd, d);
    checks++;
    if ({d, be, rd} !== {1'b1, 4'b0011, 32'hFFFF_8001}) begin
      errors++; $display("FAIL b2b_second got done %b be %b rd %h want 1 0011 ffff8001", d, be, rd);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_ack_outside_req();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum number of REQ-state cycles to wait for Bus_Ack_i before aborting.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Mem_Read_i  in  1  load request from control unit.
REQ-005 Mem_Write_i  in  1  store request from control unit.
REQ-006 funct3_i  in  3  access size/sign (instruction bits 14:12).
REQ-007 Address_i  in  32  byte address (ALU result).
REQ-008 Write_Data_i  in  32  store data (rs2).
REQ-009 Stall_o  out  1  core must hold PC/instruction while high.
REQ-010 Done_o  out  1  one-cycle pulse when the access completes or aborts.
REQ-011 Read_Data_o  out  32  extended load result, valid while Done_o is high.
REQ-012 Misaligned_o  out  1  one-cycle pulse: misaligned or illegal access.
REQ-013 Bus_Err_o  out  1  one-cycle pulse: bus timeout.
REQ-014 Bus_Req_o, Bus_We_o  out  1 each  bus request and write enable.
REQ-015 Bus_Addr_o  out  32  word-aligned address (bits 1:0 = 00).
REQ-016 Bus_Wdata_o  out  32; Bus_Be_o  out  4  lane-replicated write data and byte enables.
REQ-017 Bus_Ack_i  in  1; Bus_Rdata_i  in  32  completion and read word from memory.

Function
REQ-018 States: IDLE, REQ, DONE, ERR. Reset to IDLE.
REQ-019 IDLE, neither request: stay; Stall_o=0; no bus activity.
REQ-020 IDLE, exactly one request: decode. Legal loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores 000 SB, 001 SH, 010 SW.
REQ-021 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00. Misaligned, illegal funct3, or both requests high -> ERR, no bus request issued.
REQ-022 Legal access -> latch address, funct3, data and direction; go to REQ. Stall_o=1 combinationally in this IDLE cycle.
REQ-023 REQ: Bus_Req_o=1; Bus_We_o set per direction; address, Wdata and Be registered and stable for the whole state. Stall_o=1.
REQ-024 Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111. Reads also drive the access Be.
REQ-025 Write data: byte replicated 4x; half replicated 2x; word as-is.
REQ-026 Bus_Ack_i sampled high in REQ -> capture Bus_Rdata_i and go to DONE. Minimum latency: ack in first REQ cycle gives Done_o two cycles after the request is seen.
REQ-027 Cycle counter clears on REQ entry and increments each REQ cycle without ack. At count TIMEOUT_CYCLES-1 with no ack -> ERR with Bus_Err_o=1. Ack in that same cycle wins.
REQ-028 Load extraction: select lane by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. Stores return Read_Data_o=0.
REQ-029 DONE: Done_o=1, Stall_o=0, Read_Data_o valid; always -> IDLE.
REQ-030 ERR: Done_o=1, Stall_o=0, Read_Data_o=0, Misaligned_o or Bus_Err_o=1 per cause; always -> IDLE.
REQ-031 Bus_Ack_i outside REQ is ignored.
REQ-032 Request inputs are ignored in REQ/DONE/ERR; a new access is accepted only in IDLE.

Reset
REQ-033 On reset low, immediately (asynchronously): state=IDLE, counter=0, all latches 0, and all outputs 0 (Bus_Req_o, Done_o, Stall_o, Misaligned_o, Bus_Err_o, Read_Data_o, Bus_* = 0).
REQ-034 Reset asserted mid-REQ aborts the access with no Done_o. After release the unit stays in IDLE until a new request.

Verification
REQ-035 LW addr 0x0000_0104, ack in first REQ cycle, Rdata 0xDEAD_BEEF -> Bus_Addr_o=0x104, Be=1111, Done_o pulse 2 cycles later, Read_Data_o=0xDEAD_BEEF.
REQ-036 LB addr 0x103, Rdata 0x80FF_0000 -> Be=1000, Read_Data_o=0xFFFF_FF80. Same access as LBU -> 0x0000_0080. LH addr 0x102 -> 0xFFFF_80FF.
REQ-037 SB addr 0x201, data 0x1234_56AB -> Bus_We_o=1, Bus_Addr_o=0x200, Be=0010, Wdata=0xABAB_ABAB. SH addr 0x202 -> Be=1100, Wdata=0x56AB_56AB.
REQ-038 LW addr 0x102 -> Misaligned_o and Done_o pulse next cycle, Bus_Req_o never asserted. funct3=011 load gives the same response.
REQ-039 LW with no ack, TIMEOUT_CYCLES=16 -> Bus_Req_o high exactly 16 cycles, then Bus_Err_o+Done_o pulse with Read_Data_o=0. Ack on the 16th cycle -> normal DONE instead.
REQ-040 Reset low during REQ cycle 3 -> Bus_Req_o=0 before the next edge, no Done_o. Next LW completes normally.
